bp_update_ctrl: RTL and testbench
=================================

# bp_update_ctrl

Sequencing controller for the gshare branch predictor. After reset it sweeps every BTB/PHT index to clear stale state. It then buffers resolved branches from EX in a small FIFO and drains them into the predictor's update port at one per cycle. It also detects mispredictions and issues a one-cycle fetch redirect. It sits between the EX stage and the predictor's update inputs, and gates the predictor's fetch-hit output until the sweep completes.

## Interface
- BTB_ENTRIES, 16: BTB entry count (power of two).
- PHT_ENTRIES, 16: PHT entry count (power of two).
- Q_DEPTH, 4: update FIFO depth (power of two, ≥2).
- clk  in  1  clock.
- rst  in  1  reset, synchronous, active-low.
- exValid  in  1  EX holds a valid instruction this cycle.
- exBranch  in  1  instruction is a conditional branch or jump.
- exTaken  in  1  resolved direction.
- exPc  in  32  branch PC.
- exTarget  in  32  resolved taken target.
- exPredTaken  in  1  direction predicted at fetch.
- exPredTarget  in  32  target predicted at fetch.
- exStall  out  1  FIFO full; EX must hold its branch.
- clrValid  out  1  sweep write strobe to predictor.
- clrIndex  out  SW  sweep index; SW = clog2(max(BTB_ENTRIES, PHT_ENTRIES)).
- predEnable  out  1  predictor fetch hits may be used; 0 during sweep.
- updBranch  out  1  drives predictor exBranch.
- updTaken  out  1  drives predictor exTaken.
- updPc  out  32  drives predictor exPc.
- updTarget  out  32  drives predictor exTarget.
- redirectValid  out  1  one-cycle fetch redirect pulse.
- redirectPc  out  32  redirect address.

## Operation
- FSM states: SWEEP, RUN.
- Reset: state=SWEEP, sweep counter=0, FIFO empty, redirect cleared.
- SWEEP:
  - clrValid=1 and clrIndex=counter; counter increments each cycle.
  - On the cycle clrIndex=2^SW−1, transition to RUN.
  - predEnable=0 and updBranch=0 throughout.
  - EX branches are still accepted into the FIFO while not full.
- RUN: clrValid=0, predEnable=1.
- Enqueue:
  - Condition: exValid && exBranch && !full.
  - Entry stored: {taken, pc, target}.
  - Non-branches are never queued.
- Dequeue:
  - In RUN with FIFO non-empty, the head is presented on upd* with updBranch=1 and popped the same cycle.
  - Otherwise updBranch=0; upd* data holds the last value.
- Simultaneous enqueue and dequeue keep occupancy unchanged. This is permitted when full: full is evaluated before the pop, so exStall=1 and EX retries.
- Pointers wrap modulo Q_DEPTH. Occupancy counter is clog2(Q_DEPTH)+1 bits.
- Mispredict when exValid && exBranch and either:
  - exTaken != exPredTaken, or
  - exTaken && exPredTarget != exTarget.
- Redirect address on mispredict: exTarget if taken, else exPc+4 (32-bit wrap).
- Redirect is raised whether or not the branch is enqueued. A stalled branch re-presented next cycle raises it again; EX owns deduplication.
- Reset mid-operation (rst=0 on any edge): FIFO is discarded, no update is issued that cycle, and the sweep restarts at index 0.

## Timing
- exStall is combinational from occupancy: 1 iff count==Q_DEPTH.
- Enqueue-to-updBranch latency: 1 cycle minimum in RUN, since the entry is visible at the head the cycle after the write. There is no same-cycle bypass.
- Sweep length: exactly 2^SW cycles after the first clk edge with rst=1. The first RUN cycle is cycle 2^SW.
- redirectValid/redirectPc are registered: they pulse the cycle after the mispredicting EX cycle, for exactly one cycle per detected event.
- Reset values:
  - exStall=0, clrValid=0, clrIndex=0, predEnable=0.
  - updBranch=0, updTaken=0, updPc=0, updTarget=0.
  - redirectValid=0, redirectPc=0.
  - clrValid rises on the first cycle after rst deasserts.

## Structure
- Shared package bp_pkg holds:
  - typedef bp_upd_t {taken, pc[31:0], target[31:0]};
  - state enum {SWEEP, RUN};
  - constant for the fall-through increment (4).
- One natural sub-module: bp_upd_fifo (parameterised depth, push/pop/full/empty/head). The FSM and mispredict logic stay in the top.

## Test plan
- Reset release with PHT=BTB=16 → clrIndex counts 0..15 over 16 cycles with clrValid=1, predEnable=0; RUN entered at cycle 16.
- In RUN, single branch exPc=0x100, taken, target 0x200 → next cycle updBranch=1, updPc=0x100, updTarget=0x200, updTaken=1.
- Five back-to-back branches during SWEEP with Q_DEPTH=4 → four accepted; exStall=1 on the fifth. After RUN begins, four updates drain in order on consecutive cycles.
- Full FIFO with a simultaneous pop and a new branch → exStall=1 that cycle, branch not enqueued; accepted next cycle; order preserved.
- Mispredicts:
  - exPc=0x40, predicted taken, resolved not-taken → one cycle later redirectValid=1, redirectPc=0x44.
  - Predicted target 0x80, actual 0x90 taken → redirectPc=0x90.
- rst=0 asserted with 3 queued entries → no upd pulses afterward. The sweep restarts at clrIndex=0 after release.

Source files
------------

// File: rtl/bp_pkg.sv
// Shared types and constants for the gshare predictor update controller.
package bp_pkg;

    typedef struct packed {
        logic        taken;
        logic [31:0] pc;
        logic [31:0] target;
    } bp_upd_t;

    typedef enum logic [0:0] {
        SWEEP = 1'b0,
        RUN   = 1'b1
    } bp_state_t;

    localparam logic [31:0] FALLTHROUGH_INC = 32'd4;

endpackage

// File: rtl/bp_upd_fifo.sv
// Small FIFO of resolved branches; head is readable the cycle after the write.
module bp_upd_fifo
    import bp_pkg::*;
#(
    parameter int DEPTH = 4
) (
    input  logic    clk,
    input  logic    rst,
    input  logic    push,
    input  logic    pop,
    input  bp_upd_t din,
    output logic    full,
    output logic    empty,
    output bp_upd_t head
);

    localparam int AW = $clog2(DEPTH);

    bp_upd_t         mem [DEPTH];
    logic [AW-1:0]   wr_ptr_reg;
    logic [AW-1:0]   rd_ptr_reg;
    logic [AW:0]     count_reg;
    logic            do_push;
    logic            do_pop;

    // Full is judged on current occupancy, so a push is refused even when a pop frees a slot.
    assign full    = (count_reg == (AW + 1)'(DEPTH));
    assign empty   = (count_reg == '0);
    assign do_push = push && !full;
    assign do_pop  = pop && !empty;
    assign head    = mem[rd_ptr_reg];

    always_ff @(posedge clk) begin
        if (!rst) begin
            wr_ptr_reg <= '0;
            rd_ptr_reg <= '0;
            count_reg  <= '0;
        end else begin
            if (do_push) wr_ptr_reg <= wr_ptr_reg + 1'b1;
            if (do_pop)  rd_ptr_reg <= rd_ptr_reg + 1'b1;
            count_reg <= count_reg + (AW + 1)'(do_push) - (AW + 1)'(do_pop);
        end
    end

    always_ff @(posedge clk) begin
        if (do_push) mem[wr_ptr_reg] <= din;
    end

endmodule

// File: rtl/bp_update_ctrl.sv
// Post-reset BTB/PHT sweep, buffered predictor update drain and mispredict redirect.
module bp_update_ctrl
    import bp_pkg::*;
#(
    parameter int BTB_ENTRIES = 16,
    parameter int PHT_ENTRIES = 16,
    parameter int Q_DEPTH     = 4,
    localparam int SW = $clog2((BTB_ENTRIES > PHT_ENTRIES) ? BTB_ENTRIES : PHT_ENTRIES)
) (
    input  logic          clk,
    input  logic          rst,
    input  logic          exValid,
    input  logic          exBranch,
    input  logic          exTaken,
    input  logic [31:0]   exPc,
    input  logic [31:0]   exTarget,
    input  logic          exPredTaken,
    input  logic [31:0]   exPredTarget,
    output logic          exStall,
    output logic          clrValid,
    output logic [SW-1:0] clrIndex,
    output logic          predEnable,
    output logic          updBranch,
    output logic          updTaken,
    output logic [31:0]   updPc,
    output logic [31:0]   updTarget,
    output logic          redirectValid,
    output logic [31:0]   redirectPc
);

    bp_state_t     state_reg;
    bp_state_t     state_next;
    logic [SW-1:0] sweep_idx_reg;
    logic          sweep_live_reg;
    logic          sweep_done;

    bp_upd_t       fifo_din;
    bp_upd_t       fifo_head;
    logic          fifo_full;
    logic          fifo_empty;
    logic          upd_fire;
    bp_upd_t       upd_last_reg;

    logic          is_branch;
    logic          mispredict;
    logic [31:0]   redirect_addr;
    logic          redirect_valid_reg;
    logic [31:0]   redirect_pc_reg;

    // sweep_live_reg holds the sweep off until the first edge that sees reset released.
    assign sweep_done = (state_reg == SWEEP) && sweep_live_reg && (sweep_idx_reg == '1);

    always_comb begin
        state_next = state_reg;
        if (sweep_done) state_next = RUN;
    end

    always_ff @(posedge clk) begin
        if (!rst) begin
            state_reg      <= SWEEP;
            sweep_idx_reg  <= '0;
            sweep_live_reg <= 1'b0;
        end else begin
            state_reg      <= state_next;
            sweep_live_reg <= 1'b1;
            if (state_reg == SWEEP && sweep_live_reg) sweep_idx_reg <= sweep_idx_reg + 1'b1;
        end
    end

    assign clrValid   = (state_reg == SWEEP) && sweep_live_reg;
    assign clrIndex   = sweep_idx_reg;
    assign predEnable = (state_reg == RUN);

    assign is_branch       = exValid && exBranch;
    assign fifo_din.taken  = exTaken;
    assign fifo_din.pc     = exPc;
    assign fifo_din.target = exTarget;

    bp_upd_fifo #(
        .DEPTH (Q_DEPTH)
    ) u_fifo (
        .clk   (clk),
        .rst   (rst),
        .push  (is_branch),
        .pop   (upd_fire),
        .din   (fifo_din),
        .full  (fifo_full),
        .empty (fifo_empty),
        .head  (fifo_head)
    );

    assign exStall = fifo_full;

    // Gating with rst keeps an update off the edge on which the queue is being discarded.
    assign upd_fire = (state_reg == RUN) && !fifo_empty && rst;

    always_ff @(posedge clk) begin
        if (!rst) begin
            upd_last_reg <= '0;
        end else if (upd_fire) begin
            upd_last_reg <= fifo_head;
        end
    end

    assign updBranch = upd_fire;
    assign updTaken  = upd_fire ? fifo_head.taken  : upd_last_reg.taken;
    assign updPc     = upd_fire ? fifo_head.pc     : upd_last_reg.pc;
    assign updTarget = upd_fire ? fifo_head.target : upd_last_reg.target;

    assign mispredict    = is_branch &&
                           ((exTaken != exPredTaken) || (exTaken && (exPredTarget != exTarget)));
    assign redirect_addr = exTaken ? exTarget : (exPc + FALLTHROUGH_INC);

    always_ff @(posedge clk) begin
        if (!rst) begin
            redirect_valid_reg <= 1'b0;
            redirect_pc_reg    <= '0;
        end else begin
            redirect_valid_reg <= mispredict;
            if (mispredict) redirect_pc_reg <= redirect_addr;
        end
    end

    assign redirectValid = redirect_valid_reg;
    assign redirectPc    = redirect_pc_reg;

endmodule

// File: tb/tb_bp_update_ctrl.sv
// Directed bench for bp_update_ctrl: sweep, queueing, drain order, redirects, reset.
module tb_bp_update_ctrl;

    logic        clk = 1'b0;
    logic        rst;
    logic        exValid;
    logic        exBranch;
    logic        exTaken;
    logic [31:0] exPc;
    logic [31:0] exTarget;
    logic        exPredTaken;
    logic [31:0] exPredTarget;
    logic        exStall;
    logic        clrValid;
    logic [3:0]  clrIndex;
    logic        predEnable;
    logic        updBranch;
    logic        updTaken;
    logic [31:0] updPc;
    logic [31:0] updTarget;
    logic        redirectValid;
    logic [31:0] redirectPc;

    int n_checks = 0;
    int n_fails  = 0;

    bp_update_ctrl dut (
        .clk           (clk),
        .rst           (rst),
        .exValid       (exValid),
        .exBranch      (exBranch),
        .exTaken       (exTaken),
        .exPc          (exPc),
        .exTarget      (exTarget),
        .exPredTaken   (exPredTaken),
        .exPredTarget  (exPredTarget),
        .exStall       (exStall),
        .clrValid      (clrValid),
        .clrIndex      (clrIndex),
        .predEnable    (predEnable),
        .updBranch     (updBranch),
        .updTaken      (updTaken),
        .updPc         (updPc),
        .updTarget     (updTarget),
        .redirectValid (redirectValid),
        .redirectPc    (redirectPc)
    );

    always #5 clk = ~clk;

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_checks++;
        assert (obs === exp) else begin
            n_fails++;
            $error("FAIL %s: observed 0x%08h expected 0x%08h", tag, obs, exp);
        end
    endtask

    task automatic next_cycle();
        @(posedge clk);
        #1;
    endtask

    task automatic mid();
        @(negedge clk);
    endtask

    task automatic set_br(input logic v, input logic b, input logic t, input logic [31:0] pc,
                          input logic [31:0] tgt, input logic pt, input logic [31:0] ptgt);
        exValid      = v;
        exBranch     = b;
        exTaken      = t;
        exPc         = pc;
        exTarget     = tgt;
        exPredTaken  = pt;
        exPredTarget = ptgt;
    endtask

    task automatic idle();
        set_br(1'b0, 1'b0, 1'b0, 32'h0, 32'h0, 1'b0, 32'h0);
    endtask

    initial begin
        #200000;
        $display("FAIL watchdog: observed timeout expected completion");
        $fatal(1, "simulation timeout");
    end

    initial begin
        logic [31:0] pc_k;
        rst = 1'b0;
        idle();
        repeat (3) @(posedge clk);
        #1;

        mid();
        chk("rst_exStall",       32'(exStall),       32'd0);
        chk("rst_clrValid",      32'(clrValid),      32'd0);
        chk("rst_clrIndex",      32'(clrIndex),      32'd0);
        chk("rst_predEnable",    32'(predEnable),    32'd0);
        chk("rst_updBranch",     32'(updBranch),     32'd0);
        chk("rst_updPc",         updPc,              32'd0);
        chk("rst_updTarget",     updTarget,          32'd0);
        chk("rst_redirectValid", 32'(redirectValid), 32'd0);
        chk("rst_redirectPc",    redirectPc,         32'd0);

        next_cycle();
        rst = 1'b1;
        next_cycle();

        // Sweep with five back-to-back branches; the fifth stalls and is held.
        for (int k = 0; k < 16; k++) begin
            if (k <= 4) begin
                pc_k = 32'h1000 + 32'(k * 16);
                set_br(1'b1, 1'b1, 1'(k & 1), pc_k, pc_k + 32'h1000, 1'(k & 1), pc_k + 32'h1000);
            end
            mid();
            chk("sweep_clrValid",   32'(clrValid),   32'd1);
            chk("sweep_clrIndex",   32'(clrIndex),   32'(k));
            chk("sweep_predEnable", 32'(predEnable), 32'd0);
            chk("sweep_updBranch",  32'(updBranch),  32'd0);
            chk("sweep_exStall",    32'(exStall),    (k >= 4) ? 32'd1 : 32'd0);
            $display("sweep cycle %0d clrIndex=%0d exStall=%0d", k, clrIndex, exStall);
            next_cycle();
        end

        mid();
        chk("run_predEnable",  32'(predEnable), 32'd1);
        chk("run_clrValid",    32'(clrValid),   32'd0);
        chk("full_pop_stall",  32'(exStall),    32'd1);
        chk("drain0_updBranch", 32'(updBranch), 32'd1);
        chk("drain0_updPc",    updPc,           32'h1000);
        next_cycle();

        mid();
        chk("retry_exStall",   32'(exStall),       32'd0);
        chk("drain1_updPc",    updPc,              32'h1010);
        chk("drain1_updTaken", 32'(updTaken),      32'd1);
        chk("drain_noRedir",   32'(redirectValid), 32'd0);
        next_cycle();
        idle();

        for (int k = 2; k <= 4; k++) begin
            mid();
            chk("drain_updBranch", 32'(updBranch), 32'd1);
            chk("drain_updPc",     updPc,          32'h1000 + 32'(k * 16));
            chk("drain_updTarget", updTarget,      32'h2000 + 32'(k * 16));
            chk("drain_updTaken",  32'(updTaken),  32'(k & 1));
            $display("drain entry %0d updPc=0x%08h", k, updPc);
            next_cycle();
        end

        mid();
        chk("drained_updBranch", 32'(updBranch), 32'd0);
        chk("drained_updPc_hold", updPc,         32'h1040);

        next_cycle();
        set_br(1'b1, 1'b1, 1'b1, 32'h100, 32'h200, 1'b1, 32'h200);
        mid();
        chk("nobypass_updBranch", 32'(updBranch), 32'd0);
        next_cycle();
        idle();
        mid();
        chk("single_updBranch", 32'(updBranch),     32'd1);
        chk("single_updPc",     updPc,              32'h100);
        chk("single_updTarget", updTarget,          32'h200);
        chk("single_updTaken",  32'(updTaken),      32'd1);
        chk("single_noRedir",   32'(redirectValid), 32'd0);
        $display("single branch updPc=0x%08h updTarget=0x%08h", updPc, updTarget);

        next_cycle();
        set_br(1'b1, 1'b1, 1'b0, 32'h40, 32'h80, 1'b1, 32'h80);
        next_cycle();
        idle();
        mid();
        chk("dirmiss_redirectValid", 32'(redirectValid), 32'd1);
        chk("dirmiss_redirectPc",    redirectPc,         32'h44);
        chk("dirmiss_updTaken",      32'(updTaken),      32'd0);
        $display("direction mispredict redirectPc=0x%08h", redirectPc);
        next_cycle();
        mid();
        chk("dirmiss_pulse_end", 32'(redirectValid), 32'd0);
        chk("dirmiss_pc_hold",   redirectPc,         32'h44);

        next_cycle();
        set_br(1'b1, 1'b1, 1'b1, 32'h60, 32'h90, 1'b1, 32'h80);
        next_cycle();
        idle();
        mid();
        chk("tgtmiss_redirectValid", 32'(redirectValid), 32'd1);
        chk("tgtmiss_redirectPc",    redirectPc,         32'h90);
        chk("tgtmiss_updTarget",     updTarget,          32'h90);
        $display("target mispredict redirectPc=0x%08h", redirectPc);

        next_cycle();
        set_br(1'b1, 1'b1, 1'b0, 32'hFFFF_FFFC, 32'h500, 1'b1, 32'h500);
        next_cycle();
        idle();
        mid();
        chk("wrap_redirectValid", 32'(redirectValid), 32'd1);
        chk("wrap_redirectPc",    redirectPc,         32'h0);
        $display("wrap mispredict redirectPc=0x%08h", redirectPc);

        next_cycle();
        set_br(1'b1, 1'b0, 1'b1, 32'h700, 32'h800, 1'b0, 32'h900);
        next_cycle();
        idle();
        mid();
        chk("nonbr_redirectValid", 32'(redirectValid), 32'd0);
        chk("nonbr_updBranch",     32'(updBranch),     32'd0);
        chk("nonbr_redirectPc",    redirectPc,         32'h0);
        $display("non-branch ignored updBranch=%0d redirectValid=%0d", updBranch, redirectValid);

        // Reset while an entry sits at the head in RUN: no update may issue that cycle.
        next_cycle();
        set_br(1'b1, 1'b1, 1'b1, 32'h300, 32'h400, 1'b1, 32'h400);
        next_cycle();
        idle();
        rst = 1'b0;
        mid();
        chk("rstrun_updBranch", 32'(updBranch), 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        for (int k = 0; k < 3; k++) begin
            pc_k = 32'h3000 + 32'(k * 8);
            set_br(1'b1, 1'b1, 1'b1, pc_k, pc_k + 32'h10, 1'b1, pc_k + 32'h10);
            mid();
            chk("q3_clrIndex", 32'(clrIndex), 32'(k));
            next_cycle();
        end
        idle();
        rst = 1'b0;
        mid();
        chk("q3_rst_updBranch", 32'(updBranch), 32'd0);
        next_cycle();
        mid();
        chk("q3_rst_clrValid", 32'(clrValid), 32'd0);
        next_cycle();
        rst = 1'b1;
        next_cycle();

        for (int k = 0; k < 20; k++) begin
            mid();
            chk("resweep_updBranch", 32'(updBranch), 32'd0);
            chk("resweep_exStall",   32'(exStall),   32'd0);
            if (k < 16) begin
                chk("resweep_clrIndex", 32'(clrIndex), 32'(k));
                chk("resweep_clrValid", 32'(clrValid), 32'd1);
            end else begin
                chk("resweep_predEnable", 32'(predEnable), 32'd1);
            end
            $display("resweep cycle %0d clrIndex=%0d updBranch=%0d", k, clrIndex, updBranch);
            next_cycle();
        end

        $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fails);
        $finish;
    end

endmodule
